// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller sitting in front of a combinational
// instruction memory. It owns the fetch PC, drives the memory address
// straight from that register, captures each returned word together with
// its PC into a small prefetch FIFO, and hands instructions to decode over a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   fetch_en       run enable from core control
//   imem_addr      byte address to instruction memory (= fetch PC)
//   imem_rdata     instruction word returned in the same cycle
//   out_valid      FIFO head valid
//   out_ready      decode accepts the head
//   out_instr      head instruction (0 when out_valid=0)
//   out_pc         head PC (0 when out_valid=0)
//   redirect_valid flush-and-restart request (highest priority)
//   redirect_pc    restart byte address (low two bits ignored)
//   fault          fetch halted on an out-of-range address
//
// Optional build macro FETCH_PERF_EN adds:
//   perf_fetched   wrapping count of pushes into the FIFO
//   perf_stall     wrapping count of RUN cycles blocked by a full FIFO
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IMEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]        state;
    logic [31:0]       fetch_pc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [DATA_W-1:0] instr_q [FIFO_DEPTH];
    logic [31:0]       pc_q    [FIFO_DEPTH];

    logic pop;
    logic in_range;
    logic fetch_try;
    logic slot_free;
    logic push;
    logic fault_hit;
    logic stall;

    // Head is only ever a registered entry, so a word pushed into an empty
    // FIFO becomes visible one cycle later, never in the same cycle.
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
    assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
    assign imem_addr = fetch_pc;
    assign fault     = (state == FAULT);

    always_comb begin
        pop       = out_valid && out_ready;
        in_range  = ({2'b00, fetch_pc[31:2]} < IMEM_WORDS);
        // A redirect suppresses any fetch in its own cycle.
        fetch_try = (state == RUN) && fetch_en && !redirect_valid;
        // A full FIFO still takes a new word when the head leaves this cycle.
        slot_free = (count != DEPTH_C) || pop;
        push      = fetch_try && in_range && slot_free;
        // The fault is raised only where a push would otherwise have happened.
        fault_hit = fetch_try && !in_range && slot_free;
        stall     = fetch_try && in_range && !slot_free;
    end

    // Control: state, PC, pointers, occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            // Flush wins over a simultaneous pop; the popped word is still
            // considered consumed by decode.
            state    <= fetch_en ? RUN : IDLE;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE:    if (fetch_en) state <= RUN;
                RUN: begin
                    if (!fetch_en)      state <= IDLE;
                    else if (fault_hit) state <= FAULT;
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase

            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Data: FIFO storage, written on push only
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters survive redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)  perf_fetched <= perf_fetched + 32'd1;
            if (stall) perf_stall   <= perf_stall + 32'd1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Scoreboard bench for fetch_sequencer. The stimulus process pushes each
// expected {pc, instr} onto a queue before the cycles that deliver it; a
// monitor on the falling edge pops and compares whenever a handshake is about
// to complete. Directed checks on the address, valid and fault outputs are
// made by the stimulus process two time units after each rising edge.
// Define FETCH_PERF_EN for both files to exercise the counters.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] mem [512];
    exp_t        sb [$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[10:2]];

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] instr);
        exp_t x;
        x.pc    = pc;
        x.instr = instr;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: a handshake completes at the next rising edge unless reset.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc %h, expected no output", out_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", out_pc, e.pc);
                chk("pop_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'hfe010113;
        mem[1] = 32'h00112e23;
        mem[9] = 32'hfec42503;

        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        step(2);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_fault", 32'(fault), 0);

        // Streaming at one instruction per cycle, then fetch_en drop.
        rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        expect_word(32'h0, 32'hfe010113);
        expect_word(32'h4, 32'h00112e23);
        expect_word(32'h8, 32'hC0DE_0002);
        expect_word(32'hC, 32'hC0DE_0003);
        step(1);
        chk("s1_run_entry_valid", 32'(out_valid), 0);
        step(1);
        chk("s1_first_valid", 32'(out_valid), 1);
        chk("s1_first_pc", out_pc, 32'h0);
        chk("s1_first_instr", out_instr, 32'hfe010113);
        step(1);
        chk("s1_second_pc", out_pc, 32'h4);
        chk("s1_second_instr", out_instr, 32'h00112e23);
        step(2);
        chk("s1_fourth_pc", out_pc, 32'hC);
        chk("s1_addr", imem_addr, 32'h10);
        fetch_en = 1'b0;
        step(1);
        chk("s1_drained_valid", 32'(out_valid), 0);
        chk("s1_addr_hold", imem_addr, 32'h10);
        chk("s1_sb_empty", 32'(sb.size()), 0);

        // Back-pressure: FIFO fills with four entries and fetch stalls.
        rst_n = 1'b0; out_ready = 1'b0; fetch_en = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(5);
        chk("s2_full_addr", imem_addr, 32'h10);
        chk("s2_full_head", out_pc, 32'h0);
        step(10);
        chk("s2_stall_addr", imem_addr, 32'h10);
        chk("s2_stall_valid", 32'(out_valid), 1);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_stall", perf_fetched, 32'd4);
        chk("perf_stall_stall", perf_stall, 32'd10);
`endif
        expect_word(32'h0,  32'hfe010113);
        expect_word(32'h4,  32'h00112e23);
        expect_word(32'h8,  32'hC0DE_0002);
        expect_word(32'hC,  32'hC0DE_0003);
        expect_word(32'h10, 32'hC0DE_0004);
        out_ready = 1'b1;
        step(1);
        chk("s2_resume_addr", imem_addr, 32'h14);
        chk("s2_resume_head", out_pc, 32'h4);
        step(3);
        chk("s2_after_pops_addr", imem_addr, 32'h20);
        chk("s2_after_pops_head", out_pc, 32'h10);
        fetch_en = 1'b0;
        step(1);
        chk("s2_three_left_head", out_pc, 32'h14);
        chk("s2_three_left_addr", imem_addr, 32'h20);

        // Redirect to a misaligned target with three entries held.
        out_ready = 1'b0; fetch_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0026;
        step(1);
        chk("s3_flush_valid", 32'(out_valid), 0);
        chk("s3_flush_pc", out_pc, 32'h0);
        chk("s3_flush_instr", out_instr, 32'h0);
        chk("s3_flush_addr", imem_addr, 32'h24);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_redirect", perf_fetched, 32'd8);
        chk("perf_stall_redirect", perf_stall, 32'd10);
`endif
        redirect_valid = 1'b0; out_ready = 1'b1;
        expect_word(32'h24, 32'hfec42503);
        step(1);
        chk("s3_new_valid", 32'(out_valid), 1);
        chk("s3_new_pc", out_pc, 32'h24);
        chk("s3_new_instr", out_instr, 32'hfec42503);
        chk("s3_new_addr", imem_addr, 32'h28);

        // Redirect coinciding with a pop, to the last valid word.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_07FC;
        step(1);
        chk("s4_flush_wins_valid", 32'(out_valid), 0);
        chk("s4_addr", imem_addr, 32'h7FC);
        chk("s4_sb_empty", 32'(sb.size()), 0);
        redirect_valid = 1'b0;
        expect_word(32'h7FC, 32'hC0DE_01FF);
        step(1);
        chk("s4_last_pc", out_pc, 32'h7FC);
        chk("s4_last_instr", out_instr, 32'hC0DE_01FF);
        chk("s4_no_fault_yet", 32'(fault), 0);
        chk("s4_addr_oob", imem_addr, 32'h800);
        step(1);
        chk("s4_fault", 32'(fault), 1);
        chk("s4_fault_addr", imem_addr, 32'h800);
        chk("s4_fault_valid", 32'(out_valid), 0);
        step(2);
        chk("s4_fault_hold", 32'(fault), 1);
        chk("s4_fault_addr_hold", imem_addr, 32'h800);
        chk("s4_fault_no_push", 32'(out_valid), 0);

        // Redirect out of FAULT restarts at PC 0.
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(1);
        chk("s4_fault_cleared", 32'(fault), 0);
        chk("s4_restart_addr", imem_addr, 32'h0);
        chk("s4_restart_valid", 32'(out_valid), 0);
        redirect_valid = 1'b0;
        expect_word(32'h0, 32'hfe010113);
        step(1);
        chk("s4_restart_pc", out_pc, 32'h0);
        chk("s4_restart_instr", out_instr, 32'hfe010113);
        step(1);
        chk("s5_stream_pc", out_pc, 32'h4);
        chk("s5_stream_addr", imem_addr, 32'h8);

        // Reset mid-stream overrides a redirect and a pending handshake.
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(1);
        chk("s5_rst_valid", 32'(out_valid), 0);
        chk("s5_rst_pc", out_pc, 32'h0);
        chk("s5_rst_instr", out_instr, 32'h0);
        chk("s5_rst_addr", imem_addr, 32'h0);
        chk("s5_rst_fault", 32'(fault), 0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_rst", perf_fetched, 32'd0);
        chk("perf_stall_rst", perf_stall, 32'd0);
`endif
        rst_n = 1'b1; redirect_valid = 1'b0; fetch_en = 1'b0;
        step(1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller in front of the combinational instruction memory (512 x 32-bit words, word-indexed by address bits [.. :2]).
- Owns the fetch PC and drives the memory address.
- Captures each returned word with its PC into a small prefetch FIFO.
- Presents instructions to the decode stage over a valid/ready handshake; a redirect input (branch/jump target) flushes the FIFO and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, >= 2.
- IMEM_WORDS, 512, number of valid instruction words; a word address >= IMEM_WORDS is out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- fetch_en  in  1  run enable from core control.
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc, driven combinationally from the register.
- imem_rdata  in  32  instruction word from memory, same cycle as imem_addr.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction; 0 when out_valid=0.
- out_pc  out  32  head PC; 0 when out_valid=0.
- redirect_valid  in  1  flush and restart request.
- redirect_pc  in  32  restart byte address.
- fault  out  1  fetch stopped on an out-of-range address.

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=RESET_PC, FIFO count=0, state=IDLE, fault=0.
  - out_valid=0, out_instr=0, out_pc=0.
- States:
  - IDLE: no fetch.
  - RUN: fetching.
  - FAULT: fetch halted, fault=1.
- State transitions:
  - IDLE->RUN when fetch_en=1.
  - RUN->IDLE when fetch_en=0; FIFO contents are kept and still drain.
  - RUN->FAULT when fetch_pc[31:2] >= IMEM_WORDS and a push would otherwise occur; the out-of-range word is never pushed.
  - FAULT leaves only on redirect_valid, going to RUN if fetch_en=1, else IDLE.
- Push: in RUN with fetch_pc in range and (count<FIFO_DEPTH or a pop occurs this cycle), write {fetch_pc, imem_rdata} at tail; fetch_pc <= fetch_pc+4.
  - Addition wraps modulo 2^32.
  - Throughput is 1 instruction/cycle.
- Pop: out_valid && out_ready at a posedge removes the head.
- Push and pop in the same cycle:
  - count unchanged.
  - A full FIFO plus pop still accepts the push.
  - Empty FIFO: the pushed word appears on out_valid the next cycle, never combinationally in the same cycle.
- Latency: 1 cycle from fetch_pc presented to the instruction visible at the head (empty FIFO).
- Redirect (highest priority):
  - At posedge: count=0, fetch_pc <= {redirect_pc[31:2],2'b00} (low bits dropped), fault <= 0.
  - No push that cycle.
  - A pop handshake in the same cycle counts as consumed by decode but does not affect the flush.
  - out_valid=0 the cycle after redirect; first new instruction valid 2 cycles after the redirect edge.
  - A redirect to an out-of-range address enters RUN then FAULT on the next push attempt.
- fetch_en=0 mid-stream: pushes stop at the next edge, fetch_pc holds, pops continue.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- rst_n=0 mid-operation overrides redirect and handshake in the same cycle.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32) and perf_stall (32).
  - perf_fetched increments on every push.
  - perf_stall increments each cycle in RUN where a push is blocked because the FIFO is full with no pop.
  - Both counters wrap, reset to 0 on rst_n=0, and are not cleared by redirect.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then fetch_en=1, out_ready=1, memory word0=32'hfe010113, word1=32'h00112e23:
  - out_valid rises 1 cycle after RUN entry with out_pc=0, out_instr=32'hfe010113.
  - Next cycle out_pc=4, out_instr=32'h00112e23; one instruction per cycle thereafter.
- out_ready=0 with fetch_en=1:
  - Exactly 4 pushes, then imem_addr holds at 32'h10.
  - Raising out_ready pops PCs 0,4,8,C in order with no gap, and fetch resumes at 32'h10 in the same cycle.
- Redirect redirect_pc=32'h0000_0026 while FIFO holds 3 entries:
  - Next cycle out_valid=0 and imem_addr=32'h24.
  - Following cycle out_pc=32'h24, out_instr=memory[9]=32'hfec42503.
- Redirect to 32'h7FC (word 511):
  - Word 511 is delivered; the next cycle fault=1 and imem_addr=32'h800 with no further push.
  - Redirect to 0 clears fault and restarts at PC 0.
- Simultaneous redirect and out_valid&&out_ready, plus rst_n=0 asserted mid-stream:
  - Flush wins over the pop.
  - rst_n=0 returns all outputs to 0 and imem_addr to RESET_PC at that edge.
- With FETCH_PERF_EN defined, run the scenario-2 stall for 10 cycles:
  - perf_fetched=4 and perf_stall=10 at the end of the stall.
  - Both counters are unchanged by a subsequent redirect.
